block_order_decoder: RTL

//  Decodes a sensed three-block colour sequence back into the 4-bit order code used by the block-order encoder.

---
 rtl/block_order_pkg.sv | 43 ++++
 rtl/color_debounce.sv | 73 +++++++
 rtl/block_order_decoder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/block_order_pkg.sv
// Shared colour codes and legal block-order words for the block-order encoder and decoder.
package block_order_pkg;

  localparam logic [1:0] COL_NONE  = 2'b00;
  localparam logic [1:0] COL_RED   = 2'b01;
  localparam logic [1:0] COL_GREEN = 2'b10;
  localparam logic [1:0] COL_BLUE  = 2'b11;

  localparam int NUM_ORDERS = 6;

  // Position word is slot0 in [5:4], slot1 in [3:2], slot2 in [1:0].
  localparam logic [5:0] ORDER_WORD [NUM_ORDERS] = '{
    {COL_RED,   COL_GREEN, COL_BLUE},
    {COL_RED,   COL_BLUE,  COL_GREEN},
    {COL_GREEN, COL_RED,   COL_BLUE},
    {COL_BLUE,  COL_RED,   COL_GREEN},
    {COL_BLUE,  COL_GREEN, COL_RED},
    {COL_GREEN, COL_BLUE,  COL_RED}
  };

  localparam logic [2:0] ORDER_CODE [NUM_ORDERS] = '{
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6
  };

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SLOT0 = 3'd1,
    ST_SLOT1 = 3'd2,
    ST_SLOT2 = 3'd3,
    ST_CHECK = 3'd4
  } dec_state_t;

  // Returns {hit, code}; {0, 000} when the word is not a legal order.
  function automatic logic [3:0] match_order(input logic [5:0] word);
    logic [3:0] res;
    res = 4'b0000;
    for (int i = 0; i < NUM_ORDERS; i++) begin
      if (word == ORDER_WORD[i]) res = {1'b1, ORDER_CODE[i]};
    end
    return res;
  endfunction

endpackage

// File: rtl/color_debounce.sv
// Turns the sampled colour stream into one accept pulse per physical block.
// DECODER_DEBOUNCE_EN adds a stability counter and re-arm latch; otherwise plain edge detection.
module color_debounce
  import block_order_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       color_valid,
  input  logic [1:0] color,
  output logic       accept,
  output logic [1:0] accepted_color
);

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("STABLE_CYCLES must be at least 1");
  end

  logic active;
  assign active         = color_valid && (color != COL_NONE);
  assign accepted_color = color;

`ifdef DECODER_DEBOUNCE_EN
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_CYCLES);

  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] run_len;
  logic [1:0]    last_color;
  logic          armed;

  // Run length of identical valid colour samples before this cycle.
  assign run_len = (stable_cnt != '0 && color == last_color) ? stable_cnt : '0;
  assign accept  = armed && active && (run_len == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      idle_cnt   <= '0;
      last_color <= COL_NONE;
      armed      <= 1'b1;
    end else if (active) begin
      last_color <= color;
      idle_cnt   <= '0;
      stable_cnt <= (run_len == CNT_FULL) ? run_len : run_len + 1'b1;
      if (accept) armed <= 1'b0;
    end else begin
      stable_cnt <= '0;
      if (!armed) begin
        if (idle_cnt == CNT_LAST) begin
          armed    <= 1'b1;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic active_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) active_q <= 1'b0;
    else       active_q <= active;
  end

  assign accept = active && !active_q;
`endif

endmodule

// File: rtl/block_order_decoder.sv
// Captures three sensed block colours and decodes them into the 4-bit block-order code.
// Build option DECODER_DEBOUNCE_EN selects the debounced colour front end in color_debounce.
//
//  state    | meaning
//  IDLE     | waiting for start; outputs hold last result
//  SLOT0..2 | waiting for block n colour, timer running
//  CHECK    | result cycle: done high, start accepted
module block_order_decoder
  import block_order_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int STABLE_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       color_valid,
  input  logic [1:0] color,
  output logic [5:0] block_position,
  output logic [3:0] switches,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  dec_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    pos_d;
  logic [3:0]    sw_d;
  logic          err_d, done_d;
  logic [3:0]    decoded;
  logic          accept;
  logic [1:0]    accepted_color;

  color_debounce #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .clk           (clk),
    .reset         (reset),
    .color_valid   (color_valid),
    .color         (color),
    .accept        (accept),
    .accepted_color(accepted_color)
  );

  assign busy = (state_q == ST_SLOT0) || (state_q == ST_SLOT1) || (state_q == ST_SLOT2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      block_position <= 6'b000000;
      switches       <= 4'b0000;
      error          <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      block_position <= pos_d;
      switches       <= sw_d;
      error          <= err_d;
      done           <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pos_d   = block_position;
    sw_d    = switches;
    err_d   = error;
    done_d  = 1'b0;
    decoded = 4'b0000;

    case (state_q)
      ST_IDLE, ST_CHECK: begin
        state_d = ST_IDLE;
        if (start) begin
          pos_d   = 6'b000000;
          sw_d    = 4'b0000;
          err_d   = 1'b0;
          timer_d = '0;
          state_d = ST_SLOT0;
        end
      end
      ST_SLOT0: if (accept) begin
        pos_d[5:4] = accepted_color;
        state_d    = ST_SLOT1;
      end
      ST_SLOT1: if (accept) begin
        pos_d[3:2] = accepted_color;
        state_d    = ST_SLOT2;
      end
      ST_SLOT2: if (accept) begin
        pos_d[1:0] = accepted_color;
        decoded    = match_order(pos_d);
        sw_d       = {1'b0, decoded[2:0]};
        err_d      = !decoded[3];
        done_d     = 1'b1;
        state_d    = ST_CHECK;
      end
      default: state_d = ST_IDLE;
    endcase

    // Per-block timeout; the timer saturates rather than wrapping.
    if (busy) begin
      if (accept) begin
        timer_d = '0;
      end else if (timer_q == TIMER_LAST) begin
        state_d = ST_IDLE;
        sw_d    = 4'b0000;
        err_d   = 1'b1;
        done_d  = 1'b1;
        timer_d = '0;
      end else if (timer_q != '1) begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

endmodule
